// File: rtl/rotator_scheduler.sv
// Round-robin front end that shares one fixed-latency barrel rotator among NUM_REQ clients and returns results in issue order.
// Results appear ROT_LATENCY+1 cycles after accept; a credit counter stops issue while the result FIFO could overflow.
module rotator_scheduler #(
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_REQ     = 4,
    parameter int ROT_LATENCY = 1,
    parameter int FIFO_DEPTH  = 4,
    localparam int SA_WIDTH   = $clog2(DATA_WIDTH),
    localparam int ID_WIDTH   = $clog2(NUM_REQ)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
    input  logic [NUM_REQ*SA_WIDTH-1:0]   req_shift,
    output logic [DATA_WIDTH-1:0]         rot_data_in,
    output logic [SA_WIDTH-1:0]           rot_shift_amount,
    input  logic [DATA_WIDTH-1:0]         rot_data_out,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [ID_WIDTH-1:0]           rsp_id,
    output logic [DATA_WIDTH-1:0]         rsp_data,
    output logic                          idle
);
    localparam int CRD_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CRD_W-1:0]      credits_q, credits_d;
    logic [CRD_W-1:0]      count_q, count_d;
    logic [ID_WIDTH-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]      wr_ptr_q, rd_ptr_q;
    logic [ROT_LATENCY-1:0] tag_vld_q;
    logic [ID_WIDTH-1:0]   tag_id_q [ROT_LATENCY];
    logic [ID_WIDTH-1:0]   mem_id_q [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] mem_data_q [FIFO_DEPTH];

    logic                  can_issue, found, accept, push, pop;
    logic [ID_WIDTH-1:0]   win_id, idx;

    // Credits cover both in-flight tags and FIFO occupancy, so a push can never hit a full FIFO.
    assign can_issue = (credits_q < CRD_W'(FIFO_DEPTH));

    always_comb begin
        found  = 1'b0;
        win_id = '0;
        idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = ID_WIDTH'((int'(rr_ptr_q) + k) % NUM_REQ);
            if (!found && req_valid[idx]) begin
                found  = 1'b1;
                win_id = idx;
            end
        end
    end

    assign accept = found & can_issue;

    always_comb begin
        req_ready        = '0;
        rot_data_in      = '0;
        rot_shift_amount = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (accept && win_id == ID_WIDTH'(i)) begin
                req_ready[i]     = 1'b1;
                rot_data_in      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
                rot_shift_amount = req_shift[i*SA_WIDTH +: SA_WIDTH];
            end
        end
    end

    assign push = tag_vld_q[ROT_LATENCY-1];
    assign pop  = rsp_valid & rsp_ready;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (accept) begin
            rr_ptr_d = (win_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : win_id + ID_WIDTH'(1);
        end

        credits_d = credits_q;
        if (accept && !pop) begin
            credits_d = credits_q + CRD_W'(1);
        end else if (!accept && pop) begin
            credits_d = credits_q - CRD_W'(1);
        end

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CRD_W'(1);
        end else if (!push && pop) begin
            count_d = count_q - CRD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_ptr_q  <= '0;
            credits_q <= '0;
            count_q   <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            tag_vld_q <= '0;
            for (int i = 0; i < ROT_LATENCY; i++) begin
                tag_id_q[i] <= '0;
            end
        end else begin
            rr_ptr_q  <= rr_ptr_d;
            credits_q <= credits_d;
            count_q   <= count_d;
            tag_vld_q[0] <= accept;
            tag_id_q[0]  <= win_id;
            for (int i = 1; i < ROT_LATENCY; i++) begin
                tag_vld_q[i] <= tag_vld_q[i-1];
                tag_id_q[i]  <= tag_id_q[i-1];
            end
            if (push) begin
                wr_ptr_q <= (wr_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= (rd_ptr_q == PTR_W'(FIFO_DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
            end
        end
    end

    // Storage needs no reset: the head is only exposed while the FIFO holds an entry.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_id_q[wr_ptr_q]   <= tag_id_q[ROT_LATENCY-1];
            mem_data_q[wr_ptr_q] <= rot_data_out;
        end
    end

    assign rsp_valid = (count_q != '0);
    assign rsp_id    = rsp_valid ? mem_id_q[rd_ptr_q] : '0;
    assign rsp_data  = rsp_valid ? mem_data_q[rd_ptr_q] : '0;
    assign idle      = (credits_q == '0);

endmodule

// File: tb/tb_rotator_scheduler.sv
// Directed and random checks of rotator_scheduler with single-stage and three-stage rotator models.
module tb_rotator_scheduler;
    localparam int DW = 32;
    localparam int NR = 4;
    localparam int SW = 5;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic [NR-1:0]    req_valid, req_ready;
    logic [NR*DW-1:0] req_data;
    logic [NR*SW-1:0] req_shift;
    logic [DW-1:0]    rot_data_in, rot_data_out, rsp_data;
    logic [SW-1:0]    rot_shift_amount;
    logic             rsp_valid, rsp_ready, idle;
    logic [1:0]       rsp_id;

    logic [NR-1:0]    p_req_valid, p_req_ready;
    logic [NR*DW-1:0] p_req_data;
    logic [NR*SW-1:0] p_req_shift;
    logic [DW-1:0]    p_rot_data_in, p_rot_data_out, p_rsp_data;
    logic [SW-1:0]    p_rot_shift;
    logic             p_rsp_valid, p_rsp_ready, p_idle;
    logic [1:0]       p_rsp_id;

    int errors = 0;
    int checks = 0;
    int            exp_id[$];
    logic [DW-1:0] exp_dat[$];

    function automatic logic [DW-1:0] rotl(input logic [DW-1:0] d, input logic [SW-1:0] s);
        return (d << s) | (d >> (DW - int'(s)));
    endfunction

    // Rotator models: one register stage for u0, three for u1.
    logic [DW-1:0] p_pipe [3];
    always_ff @(posedge clk) begin
        rot_data_out <= rotl(rot_data_in, rot_shift_amount);
        p_pipe[0]    <= rotl(p_rot_data_in, p_rot_shift);
        p_pipe[1]    <= p_pipe[0];
        p_pipe[2]    <= p_pipe[1];
    end
    assign p_rot_data_out = p_pipe[2];

    rotator_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ROT_LATENCY(1), .FIFO_DEPTH(4)) u0 (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .req_data(req_data), .req_shift(req_shift), .rot_data_in(rot_data_in),
        .rot_shift_amount(rot_shift_amount), .rot_data_out(rot_data_out),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_data(rsp_data), .idle(idle)
    );

    rotator_scheduler #(.DATA_WIDTH(DW), .NUM_REQ(NR), .ROT_LATENCY(3), .FIFO_DEPTH(4)) u1 (
        .clk(clk), .reset(reset), .req_valid(p_req_valid), .req_ready(p_req_ready),
        .req_data(p_req_data), .req_shift(p_req_shift), .rot_data_in(p_rot_data_in),
        .rot_shift_amount(p_rot_shift), .rot_data_out(p_rot_data_out),
        .rsp_valid(p_rsp_valid), .rsp_ready(p_rsp_ready), .rsp_id(p_rsp_id),
        .rsp_data(p_rsp_data), .idle(p_idle)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_id.delete();
        exp_dat.delete();
    endtask

    task automatic set_reqs(input logic [DW-1:0] salt);
        for (int i = 0; i < NR; i++) begin
            req_data[i*DW +: DW]  = salt ^ (32'h1357_9BDF * (i + 1));
            req_shift[i*SW +: SW] = SW'(i * 7 + 3);
        end
    endtask

    task automatic req_exp(input int i);
        exp_id.push_back(i);
        exp_dat.push_back(rotl(req_data[i*DW +: DW], req_shift[i*SW +: SW]));
    endtask

    task automatic test_reset();
        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0; req_data = '0; req_shift = '0;
        p_req_valid = '0; p_rsp_ready = 1'b0; p_req_data = '0; p_req_shift = '0;
        tick(); tick();
        reset = 1'b0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
        checks++; if (rsp_id !== 2'd0) begin errors++; $display("FAIL reset_rsp_id: got %0d want 0", rsp_id); end
        checks++; if (rsp_data !== 32'd0) begin errors++; $display("FAIL reset_rsp_data: got %h want 0", rsp_data); end
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL reset_req_ready: got %b want 0000", req_ready); end
        checks++; if (rot_data_in !== 32'd0) begin errors++; $display("FAIL reset_rot_data: got %h want 0", rot_data_in); end
        checks++; if (rot_shift_amount !== 5'd0) begin errors++; $display("FAIL reset_rot_shift: got %0d want 0", rot_shift_amount); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %0b want 1", idle); end
        tick();
    endtask

    task automatic test_single();
        req_data[2*DW +: DW] = 32'h8000_0001;
        req_shift[2*SW +: SW] = 5'd4;
        req_valid = 4'b0100;
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL single_grant: got %b want 0100", req_ready); end
        checks++; if (rot_data_in !== 32'h8000_0001) begin errors++; $display("FAIL single_rot_data: got %h want 80000001", rot_data_in); end
        checks++; if (rot_shift_amount !== 5'd4) begin errors++; $display("FAIL single_rot_shift: got %0d want 4", rot_shift_amount); end
        tick();
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_early_rsp: got %0b want 0", rsp_valid); end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'd2 || rsp_data !== 32'h0000_0018) begin
            errors++; $display("FAIL single_rsp: got v=%0b id=%0d d=%h want v=1 id=2 d=00000018", rsp_valid, rsp_id, rsp_data);
        end
        tick();
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
            errors++; $display("FAIL single_drain: got v=%0b idle=%0b want v=0 idle=1", rsp_valid, idle);
        end
        tick();
    endtask

    task automatic test_round_robin();
        logic [3:0] exp_g;
        int e_id, nrsp;
        logic [DW-1:0] e_dat;
        do_reset();
        set_reqs(32'h0000_0000);
        req_valid = 4'hF; rsp_ready = 1'b1; nrsp = 0;
        for (int c = 0; c < 14; c++) begin
            if (c == 8) req_valid = '0;
            @(negedge clk);
            exp_g = (c < 8) ? 4'(1 << (c % 4)) : 4'b0;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rr_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
            if (c < 8) req_exp(c % 4);
            if (rsp_valid) begin
                checks++;
                if (exp_id.size() == 0) begin errors++; $display("FAIL rr_rsp_extra: got id=%0d want none", rsp_id); end
                else begin
                    e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front(); nrsp++;
                    if (rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
                        errors++; $display("FAIL rr_rsp: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, e_id, e_dat);
                    end
                end
            end
            tick();
        end
        checks++; if (nrsp != 8) begin errors++; $display("FAIL rr_rsp_count: got %0d want 8", nrsp); end
    endtask

    task automatic test_back_pressure();
        logic [3:0] exp_g;
        int e_id, nrsp, nacc;
        logic [DW-1:0] e_dat;
        do_reset();
        set_reqs(32'hCAFE_0000);
        req_valid = 4'hF; rsp_ready = 1'b0; nacc = 0; nrsp = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            exp_g = (c < 4) ? 4'(1 << c) : 4'b0;
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL bp_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
            if (c < 4) req_exp(c);
            if (req_ready != '0) nacc++;
            tick();
        end
        checks++; if (nacc != 4) begin errors++; $display("FAIL bp_accepts: got %0d want 4", nacc); end
        rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_no_bypass: got %b want 0000", req_ready); end
        e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front();
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
            errors++; $display("FAIL bp_pulse_rsp: got v=%0b id=%0d d=%h want v=1 id=%0d d=%h", rsp_valid, rsp_id, rsp_data, e_id, e_dat);
        end
        tick();
        rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL bp_reaccept: got %b want 0001", req_ready); end
        req_exp(0);
        tick();
        @(negedge clk);
        checks++; if (req_ready !== 4'b0) begin errors++; $display("FAIL bp_full_again: got %b want 0000", req_ready); end
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(exp_id[0]) || rsp_data !== exp_dat[0]) begin
            errors++; $display("FAIL bp_head_hold: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, exp_id[0], exp_dat[0]);
        end
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                if (exp_id.size() == 0) begin errors++; $display("FAIL bp_rsp_extra: got id=%0d want none", rsp_id); end
                else begin
                    e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front(); nrsp++;
                    if (rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
                        errors++; $display("FAIL bp_rsp: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, e_id, e_dat);
                    end
                end
            end
            tick();
        end
        checks++; if (nrsp != 4) begin errors++; $display("FAIL bp_drain_count: got %0d want 4", nrsp); end
    endtask

    task automatic test_simul_push_pop();
        int e_id, nrsp;
        logic [DW-1:0] e_dat;
        do_reset();
        set_reqs(32'h0BAD_F00D);
        rsp_ready = 1'b0; nrsp = 0;
        req_valid = 4'b0001;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL spp_grant0: got %b want 0001", req_ready); end
        req_exp(0);
        tick();
        req_valid = 4'b0010;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0010) begin errors++; $display("FAIL spp_grant1: got %b want 0010", req_ready); end
        req_exp(1);
        tick();
        req_valid = '0;
        tick(); tick();
        @(negedge clk);
        checks++; if (u0.credits_q !== 3'd2) begin errors++; $display("FAIL spp_credits_before: got %0d want 2", u0.credits_q); end
        tick();
        req_valid = 4'b0100; rsp_ready = 1'b1;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0100) begin errors++; $display("FAIL spp_grant2: got %b want 0100", req_ready); end
        e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front(); nrsp++;
        checks++; if (rsp_valid !== 1'b1 || rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
            errors++; $display("FAIL spp_pop_rsp: got v=%0b id=%0d d=%h want v=1 id=%0d d=%h", rsp_valid, rsp_id, rsp_data, e_id, e_dat);
        end
        req_exp(2);
        tick();
        req_valid = '0; rsp_ready = 1'b0;
        @(negedge clk);
        checks++; if (u0.credits_q !== 3'd2) begin errors++; $display("FAIL spp_credits_after: got %0d want 2", u0.credits_q); end
        tick();
        rsp_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                if (exp_id.size() == 0) begin errors++; $display("FAIL spp_rsp_extra: got id=%0d want none", rsp_id); end
                else begin
                    e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front(); nrsp++;
                    if (rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
                        errors++; $display("FAIL spp_rsp: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, e_id, e_dat);
                    end
                end
            end
            tick();
        end
        checks++; if (nrsp != 3) begin errors++; $display("FAIL spp_count: got %0d want 3", nrsp); end
    endtask

    task automatic test_reset_mid();
        logic [3:0] exp_g;
        int e_id, nrsp;
        logic [DW-1:0] e_dat;
        set_reqs(32'h7777_1234);
        req_valid = 4'hF; rsp_ready = 1'b0; nrsp = 0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            exp_g = 4'(1 << ((c + 3) % 4));
            checks++; if (req_ready !== exp_g) begin errors++; $display("FAIL rm_grant c=%0d: got %b want %b", c, req_ready, exp_g); end
            tick();
        end
        req_valid = '0;
        @(negedge clk);
        checks++; if (rsp_valid !== 1'b1 || u0.credits_q !== 3'd4) begin
            errors++; $display("FAIL rm_setup: got v=%0b credits=%0d want v=1 credits=4", rsp_valid, u0.credits_q);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        exp_id.delete(); exp_dat.delete();
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            checks++; if (rsp_valid !== 1'b0 || idle !== 1'b1) begin
                errors++; $display("FAIL rm_flushed c=%0d: got v=%0b idle=%0b want v=0 idle=1", c, rsp_valid, idle);
            end
            tick();
        end
        req_valid = 4'hF;
        @(negedge clk);
        checks++; if (req_ready !== 4'b0001) begin errors++; $display("FAIL rm_first_grant: got %b want 0001", req_ready); end
        req_exp(0);
        tick();
        req_valid = '0; rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                checks++;
                if (exp_id.size() == 0) begin errors++; $display("FAIL rm_rsp_extra: got id=%0d want none", rsp_id); end
                else begin
                    e_id = exp_id.pop_front(); e_dat = exp_dat.pop_front(); nrsp++;
                    if (rsp_id !== 2'(e_id) || rsp_data !== e_dat) begin
                        errors++; $display("FAIL rm_rsp: got id=%0d d=%h want id=%0d d=%h", rsp_id, rsp_data, e_id, e_dat);
                    end
                end
            end
            tick();
        end
        checks++; if (nrsp != 1) begin errors++; $display("FAIL rm_count: got %0d want 1", nrsp); end
    endtask

    task automatic test_pipelined();
        int            q_id[$];
        logic [DW-1:0] q_dat[$];
        logic [NR-1:0] acc;
        int            raised, n_rsp, e_id, gi;
        logic          prev_hold;
        logic [1:0]    prev_id;
        logic [DW-1:0] prev_dat, e_dat;
        acc = '0; raised = 0; n_rsp = 0; prev_hold = 1'b0; prev_id = '0; prev_dat = '0;
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (n_rsp == 1000) break;
            for (int i = 0; i < NR; i++) begin
                if (acc[i] || !p_req_valid[i]) begin
                    if (raised < 1000 && $urandom_range(0, 3) != 0) begin
                        p_req_valid[i] = 1'b1;
                        p_req_data[i*DW +: DW] = $urandom();
                        p_req_shift[i*SW +: SW] = SW'($urandom_range(0, 31));
                        raised++;
                    end else begin
                        p_req_valid[i] = 1'b0;
                    end
                end
            end
            p_rsp_ready = ($urandom_range(0, 2) != 0);
            @(negedge clk);
            checks++; if (((p_req_ready & (p_req_ready - 4'd1)) != 4'b0) || ((p_req_ready & ~p_req_valid) != 4'b0)) begin
                errors++; $display("FAIL pipe_grant: got ready=%b valid=%b want one-hot subset", p_req_ready, p_req_valid);
            end
            gi = -1;
            for (int i = 0; i < NR; i++) if (p_req_ready[i]) gi = i;
            if (gi >= 0) begin
                q_id.push_back(gi);
                q_dat.push_back(rotl(p_req_data[gi*DW +: DW], p_req_shift[gi*SW +: SW]));
            end
            acc = p_req_ready;
            if (prev_hold) begin
                checks++; if (p_rsp_valid !== 1'b1 || p_rsp_id !== prev_id || p_rsp_data !== prev_dat) begin
                    errors++; $display("FAIL pipe_stable: got v=%0b id=%0d d=%h want v=1 id=%0d d=%h", p_rsp_valid, p_rsp_id, p_rsp_data, prev_id, prev_dat);
                end
            end
            if (p_rsp_valid && p_rsp_ready) begin
                checks++;
                if (q_id.size() == 0) begin errors++; $display("FAIL pipe_rsp_extra: got id=%0d want none", p_rsp_id); end
                else begin
                    e_id = q_id.pop_front(); e_dat = q_dat.pop_front(); n_rsp++;
                    if (p_rsp_id !== 2'(e_id) || p_rsp_data !== e_dat) begin
                        errors++; $display("FAIL pipe_rsp #%0d: got id=%0d d=%h want id=%0d d=%h", n_rsp, p_rsp_id, p_rsp_data, e_id, e_dat);
                    end
                end
            end
            prev_hold = p_rsp_valid && !p_rsp_ready;
            prev_id = p_rsp_id;
            prev_dat = p_rsp_data;
            tick();
        end
        p_req_valid = '0;
        checks++; if (n_rsp != 1000) begin errors++; $display("FAIL pipe_count: got %0d want 1000 (cycle budget)", n_rsp); end
        @(negedge clk);
        checks++; if (p_idle !== 1'b1 || p_rsp_valid !== 1'b0) begin
            errors++; $display("FAIL pipe_idle: got idle=%0b v=%0b want idle=1 v=0", p_idle, p_rsp_valid);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_back_pressure();
        test_simul_push_pop();
        test_reset_mid();
        test_pipelined();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
